// File: rtl/binary_search_engine.sv
// Binary search over a sorted ascending table in an external synchronous RAM.
// Optional probe counter output is enabled by defining BSEARCH_PROBE_COUNT_EN.
module binary_search_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] key,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W:0]   loc
`ifdef BSEARCH_PROBE_COUNT_EN
  ,
  output logic [ADDR_W+1:0] probes
`endif
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam int                CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     lo_q, lo_d, hi_q, hi_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                found_q, found_d;
  logic [ADDR_W:0]     loc_q, loc_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic                mode_q, mode_d;
  logic [ADDR_W+1:0]   sum_w;
  logic [ADDR_W:0]     mid_w;
`ifdef BSEARCH_PROBE_COUNT_EN
  logic [ADDR_W+1:0]   probes_q, probes_d;
`endif

  // Extra bit on the sum keeps lo+hi from wrapping when hi == DEPTH.
  assign sum_w = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid_w = (ADDR_W + 1)'(sum_w >> 1);

  assign busy     = (state_q == S_PROBE) || (state_q == S_CMP);
  assign done     = (state_q == S_DONE);
  assign mem_addr = busy ? mid_w[ADDR_W-1:0] : '0;
  assign found    = found_q;
  assign loc      = loc_q;
`ifdef BSEARCH_PROBE_COUNT_EN
  assign probes   = probes_q;
`endif

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    loc_d    = loc_q;
    key_d    = key_q;
    mode_d   = mode_q;
`ifdef BSEARCH_PROBE_COUNT_EN
    probes_d = probes_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key;
          mode_d  = mode;
          lo_d    = '0;
          hi_d    = DEPTH_V;
          cnt_d   = '0;
          found_d = 1'b0;
          loc_d   = '0;
`ifdef BSEARCH_PROBE_COUNT_EN
          probes_d = '0;
`endif
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CMP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CMP: begin
`ifdef BSEARCH_PROBE_COUNT_EN
        probes_d = probes_q + 1'b1;
`endif
        if (!mode_q && (mem_rdata == key_q)) begin
          found_d = 1'b1;
          loc_d   = mid_w;
          state_d = S_DONE;
        end else begin
          if (mem_rdata < key_q) lo_d = mid_w + 1'b1;
          else                   hi_d = mid_w;
          // Window collapsed: lo is the insertion point / lower bound.
          if (lo_d == hi_d) begin
            loc_d   = lo_d;
            found_d = mode_q && (lo_d < DEPTH_V);
            state_d = S_DONE;
          end else begin
            state_d = S_PROBE;
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      loc_q    <= '0;
`ifdef BSEARCH_PROBE_COUNT_EN
      probes_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      loc_q    <= loc_d;
`ifdef BSEARCH_PROBE_COUNT_EN
      probes_q <= probes_d;
`endif
    end
  end

  // Search operands only matter once accepted, so they carry no reset.
  always_ff @(posedge CLOCK_50) begin
    key_q  <= key_d;
    mode_q <= mode_d;
  end

endmodule

// File: tb/tb_binary_search_engine.sv
// Directed bench for binary_search_engine: two instances (RD_LAT=1 and RD_LAT=2)
// over a table mem[i] = 2*i.
module tb_binary_search_engine;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, start1, mode1, busy1, done1, found1;
  logic [7:0] key1, rdata1;
  logic [4:0] addr1;
  logic [5:0] loc1;
  logic       rst2, start2, mode2, busy2, done2, found2;
  logic [7:0] key2, rdata2, stage2;
  logic [4:0] addr2;
  logic [5:0] loc2;
`ifdef BSEARCH_PROBE_COUNT_EN
  logic [6:0] probes1, probes2;
`endif

  int n_vec = 0;
  int n_err = 0;

  binary_search_engine #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1)) dut1 (
    .CLOCK_50(clk), .Reset(rst1), .start(start1), .mode(mode1), .key(key1),
    .mem_addr(addr1), .mem_rdata(rdata1), .busy(busy1), .done(done1),
    .found(found1), .loc(loc1)
`ifdef BSEARCH_PROBE_COUNT_EN
    , .probes(probes1)
`endif
  );

  binary_search_engine #(.DATA_W(8), .ADDR_W(5), .RD_LAT(2)) dut2 (
    .CLOCK_50(clk), .Reset(rst2), .start(start2), .mode(mode2), .key(key2),
    .mem_addr(addr2), .mem_rdata(rdata2), .busy(busy2), .done(done2),
    .found(found2), .loc(loc2)
`ifdef BSEARCH_PROBE_COUNT_EN
    , .probes(probes2)
`endif
  );

  // Table memories: one- and two-cycle read latency.
  always @(posedge clk) begin
    rdata1 <= {2'b00, addr1, 1'b0};
    stage2 <= {2'b00, addr2, 1'b0};
    rdata2 <= stage2;
  end

  task automatic run1(input logic [7:0] k, input logic m, output int cyc);
    start1 = 1'b1; key1 = k; mode1 = m;
    @(posedge clk); #1;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic release1();
    start1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    key1 = '0; key2 = '0; mode1 = 1'b0; mode2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0; rst2 = 1'b0;
    n_vec++; if ({busy1, done1, found1} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags got=%b want=000", {busy1, done1, found1}); end
    n_vec++; if (loc1 !== 6'd0) begin n_err++;
      $display("FAIL reset_loc got=%0d want=0", loc1); end
    n_vec++; if (addr1 !== 5'd0) begin n_err++;
      $display("FAIL reset_addr got=%0d want=0", addr1); end
  endtask

  task automatic test_exact_hit();
    int cyc;
    run1(8'd4, 1'b0, cyc);
    n_vec++; if (cyc != 8) begin n_err++;
      $display("FAIL hit4_latency got=%0d want=8", cyc); end
    n_vec++; if ({found1, loc1} !== {1'b1, 6'd2}) begin n_err++;
      $display("FAIL hit4_result got found=%b loc=%0d want found=1 loc=2", found1, loc1); end
`ifdef BSEARCH_PROBE_COUNT_EN
    n_vec++; if (probes1 !== 7'd4) begin n_err++;
      $display("FAIL hit4_probes got=%0d want=4", probes1); end
`endif
    @(posedge clk); #1;
    n_vec++; if ({done1, busy1} !== 2'b10) begin n_err++;
      $display("FAIL hit4_hold got done,busy=%b want=10", {done1, busy1}); end
    release1();
    n_vec++; if ({done1, busy1, found1, loc1} !== {3'b001, 6'd2}) begin n_err++;
      $display("FAIL hit4_idle got done=%b busy=%b found=%b loc=%0d want 0 0 1 2",
               done1, busy1, found1, loc1); end
  endtask

  task automatic test_miss();
    int cyc;
    run1(8'd5, 1'b0, cyc);
    n_vec++; if ({found1, loc1} !== {1'b0, 6'd3} || cyc != 10) begin n_err++;
      $display("FAIL miss5_exact got found=%b loc=%0d cyc=%0d want 0 3 10", found1, loc1, cyc); end
`ifdef BSEARCH_PROBE_COUNT_EN
    n_vec++; if (probes1 !== 7'd5) begin n_err++;
      $display("FAIL miss5_probes got=%0d want=5", probes1); end
`endif
    release1();
    run1(8'd5, 1'b1, cyc);
    n_vec++; if ({found1, loc1} !== {1'b1, 6'd3}) begin n_err++;
      $display("FAIL lb5 got found=%b loc=%0d want found=1 loc=3", found1, loc1); end
    release1();
  endtask

  task automatic test_bounds();
    int cyc;
    run1(8'd63, 1'b1, cyc);
    n_vec++; if ({found1, loc1} !== {1'b0, 6'd32} || cyc != 10) begin n_err++;
      $display("FAIL lb63 got found=%b loc=%0d cyc=%0d want 0 32 10", found1, loc1, cyc); end
`ifdef BSEARCH_PROBE_COUNT_EN
    n_vec++; if (probes1 !== 7'd5) begin n_err++;
      $display("FAIL lb63_probes got=%0d want=5", probes1); end
`endif
    release1();
    run1(8'd0, 1'b0, cyc);
    n_vec++; if ({found1, loc1} !== {1'b1, 6'd0} || cyc != 12) begin n_err++;
      $display("FAIL hit0 got found=%b loc=%0d cyc=%0d want 1 0 12", found1, loc1, cyc); end
`ifdef BSEARCH_PROBE_COUNT_EN
    n_vec++; if (probes1 !== 7'd6) begin n_err++;
      $display("FAIL hit0_probes got=%0d want=6", probes1); end
`endif
    release1();
  endtask

  task automatic test_rdlat2();
    int exp_a[9] = '{16, 16, 16, 24, 24, 24, 20, 20, 20};
    start2 = 1'b1; key2 = 8'd40; mode2 = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 9; c++) begin
      n_vec++; if (addr2 !== 5'(exp_a[c]) || done2 !== 1'b0) begin n_err++;
        $display("FAIL lat2_addr cyc=%0d got addr=%0d done=%b want addr=%0d done=0",
                 c, addr2, done2, exp_a[c]); end
      @(posedge clk); #1;
    end
    n_vec++; if ({done2, found2, loc2} !== {2'b11, 6'd20}) begin n_err++;
      $display("FAIL lat2_result got done=%b found=%b loc=%0d want 1 1 20", done2, found2, loc2); end
`ifdef BSEARCH_PROBE_COUNT_EN
    n_vec++; if (probes2 !== 7'd3) begin n_err++;
      $display("FAIL lat2_probes got=%0d want=3", probes2); end
`endif
    start2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    n_vec++; if ({found2, loc2} !== {1'b1, 6'd20}) begin n_err++;
      $display("FAIL idle_retain got found=%b loc=%0d want 1 20", found2, loc2); end
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    n_vec++; if ({found2, loc2} !== {1'b0, 6'd0}) begin n_err++;
      $display("FAIL idle_reset got found=%b loc=%0d want 0 0", found2, loc2); end
    start2 = 1'b1; key2 = 8'd40; mode2 = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    n_vec++; if ({busy2, addr2} !== {1'b1, 5'd20}) begin n_err++;
      $display("FAIL mid_probe3 got busy=%b addr=%0d want 1 20", busy2, addr2); end
    rst2 = 1'b1; start2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b0;
    n_vec++; if ({busy2, done2, found2, loc2, addr2} !== {3'b000, 6'd0, 5'd0}) begin n_err++;
      $display("FAIL mid_reset got busy=%b done=%b found=%b loc=%0d addr=%0d want all 0",
               busy2, done2, found2, loc2, addr2); end
  endtask

  task automatic test_key_change();
    int cyc;
    start2 = 1'b1; key2 = 8'd10; mode2 = 1'b0;
    @(posedge clk); #1;
    key2 = 8'd99; mode2 = 1'b1;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++; if ({found2, loc2} !== {1'b1, 6'd5} || cyc != 15) begin n_err++;
      $display("FAIL key10 got found=%b loc=%0d cyc=%0d want 1 5 15", found2, loc2, cyc); end
    start2 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (done2 !== 1'b0) begin n_err++;
      $display("FAIL key10_release got done=%b want 0", done2); end
  endtask

  initial begin
    test_reset();
    test_exact_hit();
    test_miss();
    test_bounds();
    test_rdlat2();
    test_reset_mid();
    test_key_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/binary_search_engine.md
Name: binary_search_engine

Overview:
- Parametrised binary-search engine over a sorted, ascending, unsigned table held in an external synchronous memory.
- Supports configurable data width, depth, memory read latency, and two search modes:
  - exact match, which also reports the insertion point on a miss;
  - lower bound, which returns the first index whose entry is greater than or equal to the key.
- Sits between board-level key/switch glue and a RAM block; the 7-segment and LED wrappers consume its outputs.

Parameters:
- DATA_W, 8, width of key and memory words.
- ADDR_W, 5, address width; table depth DEPTH = 2**ADDR_W.
- RD_LAT, 1, memory read latency in cycles (legal range 1..4); mem_rdata is valid RD_LAT cycles after mem_addr is presented.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous reset, active-high.
- start  in  1  level request; accepted only in IDLE.
- mode  in  1  0 = exact match, 1 = lower bound; latched on accept.
- key  in  DATA_W  search value; latched on accept.
- mem_addr  out  ADDR_W  read address to memory.
- mem_rdata  in  DATA_W  read data from memory.
- busy  out  1  high in PROBE and CMP.
- done  out  1  high in DONE.
- found  out  1  result flag.
- loc  out  ADDR_W+1  result index; range 0..DEPTH.

Behaviour:
- Reset (synchronous, active-high, effective at any state including mid-search): state goes to IDLE; busy=0, done=0, found=0, loc=0, mem_addr=0; lo, hi and the latency counter are cleared.
- Registers:
  - lo, hi: ADDR_W+1 bits each; hi is exclusive.
  - key_q, mode_q.
  - wait counter: clog2(RD_LAT+1) bits.
- mid = (lo+hi)>>1, computed in ADDR_W+2 bits so the sum cannot overflow; the low ADDR_W bits drive mem_addr in PROBE and CMP.
- State machine:
  - IDLE: when start=1, latch key and mode, set lo=0 and hi=DEPTH, clear found and loc, and go to PROBE.
  - PROBE: hold mem_addr=mid for RD_LAT cycles (counter), then go to CMP.
  - CMP: sample mem_rdata.
    - Exact mode, mem_rdata==key_q: found=1, loc=mid, go to DONE.
    - mem_rdata<key_q: lo=mid+1.
    - Otherwise: hi=mid.
    - If the updated lo equals the updated hi, go to DONE. Otherwise go to PROBE.
  - DONE, on entry from the lo==hi exit:
    - loc=lo.
    - Exact mode: found=0.
    - Lower-bound mode: found=(lo<DEPTH).
  - DONE: done=1. Stay while start=1 (no retrigger while held). Go to IDLE when start=0.
- found and loc hold their values through IDLE until the next accept.
- Timing:
  - Each probe costs RD_LAT+1 cycles.
  - Probe count ≤ ADDR_W+1.
  - done rises (RD_LAT+1)×P cycles after the first PROBE cycle, where P is the number of probes.
- Comparison is unsigned. key, mode and start changes during PROBE/CMP are ignored.
- loc=DEPTH on a miss means the key is greater than every entry.

Optional Feature:
- Macro: BSEARCH_PROBE_COUNT_EN.
- When defined:
  - Adds output port probes (ADDR_W+2 bits).
  - probes clears on accept and on Reset, increments once per CMP, and holds in DONE/IDLE.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- All cases use DEPTH=32 and mem[i]=2*i (0..62); probe counts apply with BSEARCH_PROBE_COUNT_EN defined.
- RD_LAT=1, mode=0, key=4 -> found=1, loc=2, 4 probes; done rises 8 cycles after the first PROBE cycle; done held until start drops, then IDLE with found/loc retained.
- mode=0, key=5 -> found=0, loc=3 (insertion point), 5 probes. Same key with mode=1 -> found=1, loc=3.
- mode=1, key=63 -> found=0, loc=32, 5 probes. mode=0, key=0 -> found=1, loc=0, 6 probes (the maximum).
- RD_LAT=2, mode=0, key=40 -> found=1, loc=20, 3 probes; done 9 cycles after the first PROBE; mem_addr stable 16 → 24 → 20 across each wait.
- Reset pulsed during the third probe of a search for key=40 -> next cycle IDLE with busy=0, done=0, found=0, loc=0. A new start with key=10 -> found=1, loc=5. A key change mid-search does not alter the result.
